// File: rtl/pattern_pipe_chain.sv
// pattern_pipe_chain
//   DEPTH registered pattern stages, WIDTH bits each, joined by a valid/ready
//   handshake so that backpressure stalls the chain without losing data.
//   Every stage applies the pattern function f(x): with j = (i+1) mod WIDTH,
//   even bit i is NOR(x[i], x[j]) and odd bit i is NAND(x[i], x[j]).
//   A wrap-around counter of output handshakes is always built. An output
//   signature register is built only when PATTERN_PIPE_MISR_EN is defined.
//
// Parameters
//   WIDTH  data width per stage (2..64)
//   DEPTH  number of pattern stages (1..16)
//   CNT_W  width of the transfer counter
//
// Ports
//   blif_clk_net    in   clock
//   blif_reset_net  in   asynchronous active-low reset
//   in_valid        in   upstream data valid
//   in_ready        out  stage 0 can accept (combinational from out_ready)
//   in_data         in   upstream pattern vector
//   out_valid       out  last stage holds valid data
//   out_ready       in   downstream accepts data
//   out_data        out  last-stage register
//   xfer_cnt        out  count of output handshakes, wraps to 0
//   sig_clr         in   synchronous signature clear (ignored without MISR)
//   sig_out         out  output signature (0 without MISR)

module pattern_pipe_chain #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 2,
    parameter int unsigned CNT_W = 16
) (
    input  logic             blif_clk_net,
    input  logic             blif_reset_net,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] xfer_cnt,
    input  logic             sig_clr,
    output logic [WIDTH-1:0] sig_out
);

    logic [DEPTH-1:0][WIDTH-1:0] r_s;
    logic [DEPTH-1:0]            r_v;
    logic [DEPTH-1:0]            w_take;
    logic                        w_out_hs;
    logic [CNT_W-1:0]            r_xfer_cnt;

    function automatic logic [WIDTH-1:0] pat_f(input logic [WIDTH-1:0] x);
        logic [WIDTH-1:0] y;
        y = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (i[0] == 1'b0)
                y[i] = ~(x[i] | x[(i + 1) % WIDTH]);
            else
                y[i] = ~(x[i] & x[(i + 1) % WIDTH]);
        end
        return y;
    endfunction

    // A stage may load when it is empty or when the stage after it may load;
    // the last stage frees on out_ready. Walked from the output backwards so a
    // full chain frees entirely in the cycle out_ready rises.
    always_comb begin
        logic l_take;
        w_take          = '0;
        l_take          = ~r_v[DEPTH-1] | out_ready;
        w_take[DEPTH-1] = l_take;
        for (int unsigned n = 1; n < DEPTH; n++) begin
            l_take              = ~r_v[DEPTH-1-n] | l_take;
            w_take[DEPTH-1-n]   = l_take;
        end
    end

    always_ff @(posedge blif_clk_net or negedge blif_reset_net) begin
        if (!blif_reset_net) begin
            r_v <= '0;
            r_s <= '0;
        end else begin
            if (w_take[0]) begin
                r_v[0] <= in_valid;
                if (in_valid)
                    r_s[0] <= pat_f(in_data);
            end
            for (int unsigned k = 1; k < DEPTH; k++) begin
                if (w_take[k]) begin
                    r_v[k] <= r_v[k-1];
                    if (r_v[k-1])
                        r_s[k] <= pat_f(r_s[k-1]);
                end
            end
        end
    end

    assign w_out_hs  = r_v[DEPTH-1] & out_ready;
    assign in_ready  = w_take[0];
    assign out_valid = r_v[DEPTH-1];
    assign out_data  = r_s[DEPTH-1];

    always_ff @(posedge blif_clk_net or negedge blif_reset_net) begin
        if (!blif_reset_net)
            r_xfer_cnt <= '0;
        else if (w_out_hs)
            r_xfer_cnt <= r_xfer_cnt + CNT_W'(1);
    end

    assign xfer_cnt = r_xfer_cnt;

`ifdef PATTERN_PIPE_MISR_EN
    logic [WIDTH-1:0] r_sig;

    // Clear wins over a same-cycle handshake update.
    always_ff @(posedge blif_clk_net or negedge blif_reset_net) begin
        if (!blif_reset_net)
            r_sig <= '0;
        else if (sig_clr)
            r_sig <= '0;
        else if (w_out_hs)
            r_sig <= {r_sig[WIDTH-2:0], r_sig[WIDTH-1]} ^ r_s[DEPTH-1];
    end

    assign sig_out = r_sig;
`else
    logic w_unused_sig_clr;
    assign w_unused_sig_clr = sig_clr;
    assign sig_out          = '0;
`endif

endmodule
